button_pulse_array: RTL and testbench
=====================================

// Module: button_pulse_array
// PURPOSE
//  Multi-channel button conditioner for the watch front panel: per channel, 2-flop sync, debounce,
//  one-cycle press pulse, optional hold-to-repeat pulses. Successor to the single-channel pulse
//  generator; sits between raw push-button pins and mode/set FSMs, which consume osign[i] as a
//  single-cycle "advance" strobe.
// PARAMETERS
//  CHANNELS       4    number of independent buttons (>=1)
//  DEB_CYCLES     4    consecutive stable sampled cycles required to change debounced level (>=1)
//  REPEAT_DELAY   500  cycles from first press pulse to first repeat pulse (>=2)
//  REPEAT_PERIOD  100  cycles between successive repeat pulses (>=2)
// PORTS
//  clk     in   1         system clock, all logic on posedge
//  reset   in   1         synchronous, active-high
//  isign   in   CHANNELS  raw button levels, asynchronous, 1 = pressed
//  osign   out  CHANNELS  registered one-cycle pulse per press / repeat
//  olevel  out  CHANNELS  registered debounced level
// BEHAVIOUR
//  Reset: one clock; synchronous, active-high. Clears sync flops, debounced levels, counters, FSMs
//   to IDLE; osign=0, olevel=0 from the edge where reset is sampled high. Mid-operation reset
//   aborts any count/repeat. A button held through reset release is treated as a new press.
//  Sync: s1<=isign[i]; s2<=s1. Debounce: cnt clears whenever s2==olevel[i]; increments while
//   s2!=olevel[i]; on the edge where s2 has differed for DEB_CYCLES consecutive edges,
//   olevel[i]<=s2 and cnt<=0. Glitches shorter than DEB_CYCLES are rejected entirely.
//  Per-channel FSM (states: IDLE, PULSE, HOLD, RPT); osign[i]=1 iff state is PULSE or RPT:
//   IDLE : olevel=1 -> PULSE, else IDLE
//   PULSE: olevel=0 -> IDLE, else HOLD (rep counter loaded for REPEAT_DELAY)
//   HOLD : olevel=0 -> IDLE; else when rep counter expires -> RPT
//   RPT  : olevel=0 -> IDLE, else HOLD (rep counter loaded for REPEAT_PERIOD)
//  Latency: isign first sampled high at edge E0 and stable -> olevel high after edge
//   E0+1+DEB_CYCLES; osign high for exactly the cycle after edge E0+2+DEB_CYCLES.
//  Repeat timing: RPT pulse begins exactly REPEAT_DELAY cycles after PULSE cycle; each later
//   RPT exactly REPEAT_PERIOD cycles after previous RPT. Release (olevel falling) never pulses;
//   release coinciding with counter expiry -> IDLE, no pulse.
//  Rep counter width = $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1); counts down, reloads, never wraps.
//  Channels fully independent; simultaneous presses produce simultaneous pulses. Unused state
//   encodings -> IDLE.
// CONFIGURATION
//  BTN_AUTOREPEAT_EN defined: HOLD/RPT repeat behaviour as above.
//  Not defined: rep counter and RPT state not built; HOLD exits only on release; exactly one
//   osign pulse per debounced press, regardless of hold time. REPEAT_* parameters ignored.
// STRUCTURE
//  Package btn_pkg: FSM state typedef (IDLE/PULSE/HOLD/RPT, 2-bit), counter-width function.
//  Sub-module btn_chan: one channel (sync, debounce, FSM, rep counter); top instantiates
//   CHANNELS copies in a generate loop and concatenates outputs. No logic in top beyond wiring.
// TESTING (CHANNELS=2, DEB_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3)
//  1. reset 2 cycles, isign=0 -> osign=0, olevel=0 throughout; FSM IDLE.
//  2. isign[0] 0->1 sampled at edge 10, held 6 cycles -> olevel[0]=1 after edge 15; osign[0]=1
//     only in cycle after edge 16; osign[1] stays 0.
//  3. isign[0] 3-cycle high glitch -> olevel[0], osign[0] never assert.
//  4. AUTOREPEAT on, hold isign[0] 30 cycles -> pulses at PULSE cycle T, then T+8, T+11, T+14...;
//     release -> no further pulse, no pulse on release.
//  5. AUTOREPEAT off, same hold -> exactly one osign[0] pulse.
//  6. both channels pressed same edge, reset asserted mid-hold -> simultaneous pulses; outputs 0
//     after reset edge; held buttons re-pulse DEB_CYCLES+3 edges after reset release.

Source files
------------

// File: rtl/btn_pkg.sv
// btn_pkg: shared types and helpers for the button pulse array.
//   btn_state_t : per-channel FSM state (IDLE/PULSE/HOLD/RPT), 2-bit encoding
//   rep_width() : bit width of the repeat down-counter
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2,
        RPT   = 2'd3
    } btn_state_t;

    function automatic int rep_width(input int delay, input int period);
        return $clog2((delay > period ? delay : period) + 1);
    endfunction

endpackage

// File: rtl/button_pulse_array_if.sv
// button_pulse_array_if: button bundle between the raw pins and the conditioned strobes.
//   isign  : raw asynchronous button levels, 1 = pressed (driven by master)
//   osign  : one-cycle press/repeat pulses (driven by slave)
//   olevel : debounced levels (driven by slave)
interface button_pulse_array_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] isign;
    logic [CHANNELS-1:0] osign;
    logic [CHANNELS-1:0] olevel;

    modport master (output isign, input osign, olevel);
    modport slave  (input isign, output osign, olevel);
endinterface

// File: rtl/btn_chan.sv
// btn_chan: one button channel - 2-flop sync, debounce, press pulse FSM, optional hold-to-repeat.
//   clk    : system clock
//   reset  : synchronous, active-high
//   isign  : raw button level
//   osign  : registered one-cycle pulse per press (and per repeat)
//   olevel : registered debounced level
// Hold-to-repeat is built only when BTN_AUTOREPEAT_EN is defined.
module btn_chan
    import btn_pkg::*;
#(
    parameter int DEB_CYCLES    = 4,
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic isign,
    output logic osign,
    output logic olevel
);
    localparam int DW = $clog2(DEB_CYCLES + 1);

    logic          s1, s2;
    logic [DW-1:0] cnt;
    btn_state_t    state, state_n;

    // The level flips on the edge that completes DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            cnt    <= '0;
            olevel <= 1'b0;
        end else begin
            s1 <= isign;
            s2 <= s1;
            if (s2 == olevel) begin
                cnt <= '0;
            end else if (cnt == DW'(DEB_CYCLES - 1)) begin
                olevel <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + DW'(1);
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RW = rep_width(REPEAT_DELAY, REPEAT_PERIOD);

    logic [RW-1:0] rep, rep_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            rep   <= '0;
            osign <= 1'b0;
        end else begin
            state <= state_n;
            rep   <= rep_n;
            osign <= (state_n == PULSE) || (state_n == RPT);
        end
    end

    // HOLD lasts load+1 cycles, so loading N-2 puts the next pulse exactly N cycles on.
    always_comb begin
        state_n = IDLE;
        rep_n   = rep;
        case (state)
            IDLE: state_n = olevel ? PULSE : IDLE;
            PULSE: begin
                state_n = olevel ? HOLD : IDLE;
                rep_n   = RW'(REPEAT_DELAY - 2);
            end
            HOLD: begin
                state_n = !olevel ? IDLE : (rep == '0 ? RPT : HOLD);
                rep_n   = (rep == '0) ? rep : rep - RW'(1);
            end
            RPT: begin
                state_n = olevel ? HOLD : IDLE;
                rep_n   = RW'(REPEAT_PERIOD - 2);
            end
            default: state_n = IDLE;
        endcase
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            osign <= 1'b0;
        end else begin
            state <= state_n;
            osign <= (state_n == PULSE);
        end
    end

    always_comb begin
        state_n = IDLE;
        case (state)
            IDLE:    state_n = olevel ? PULSE : IDLE;
            PULSE:   state_n = olevel ? HOLD : IDLE;
            HOLD:    state_n = olevel ? HOLD : IDLE;
            default: state_n = IDLE;
        endcase
    end
`endif

endmodule

// File: rtl/button_pulse_array.sv
// button_pulse_array: multi-channel button conditioner built from independent btn_chan copies.
//   clk          : system clock
//   reset        : synchronous, active-high
//   bus.isign    : raw button levels (CHANNELS bits)
//   bus.osign    : one-cycle press/repeat pulses (CHANNELS bits)
//   bus.olevel   : debounced levels (CHANNELS bits)
// Define BTN_AUTOREPEAT_EN to enable hold-to-repeat pulses.
module button_pulse_array #(
    parameter int CHANNELS      = 4,
    parameter int DEB_CYCLES    = 4,
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100
) (
    input logic                 clk,
    input logic                 reset,
    button_pulse_array_if.slave bus
);
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        btn_chan #(
            .DEB_CYCLES   (DEB_CYCLES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_chan (
            .clk   (clk),
            .reset (reset),
            .isign (bus.isign[i]),
            .osign (bus.osign[i]),
            .olevel(bus.olevel[i])
        );
    end

endmodule

// File: tb/tb_button_pulse_array.sv
// tb_button_pulse_array: random and directed stimulus checked every cycle against a window-based model.
module tb_button_pulse_array;
    localparam int CH  = 2;
    localparam int DEB = 4;
    localparam int RD  = 8;
    localparam int RP  = 3;
    localparam int HN  = 4096;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    button_pulse_array_if #(.CHANNELS(CH)) bus();

    button_pulse_array #(
        .CHANNELS(CH), .DEB_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // Model: raw samples since reset; the level flips when the last DEB synchronised samples
    // (sample delayed two edges) all disagree with it and none predate the previous flip.
    // Pulses fall k edges after the rise+1, k = 0 or RD + n*RP, while the level stays high.
    bit          hist [CH][HN];
    bit          lvl [CH];
    int          rise [CH];
    int          last_flip [CH];
    int          t = 0;
    bit          valid = 1'b0;
    logic [CH-1:0] exp_os = '0;
    logic [CH-1:0] exp_lv = '0;

    function automatic bit s2_at(input int c, input int e);
        return (e >= 2) ? hist[c][e-2] : 1'b0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            t = 0;
            valid = 1'b1;
            exp_os = '0;
            exp_lv = '0;
            for (int c = 0; c < CH; c++) begin
                lvl[c] = 1'b0;
                rise[c] = -1;
                last_flip[c] = -1;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                int k;
                bit all;
                if (t < HN) hist[c][t] = bus.isign[c];
                k = t - rise[c] - 1;
                exp_os[c] = lvl[c] && rise[c] >= 0 &&
                            (k == 0 || (AUTO && k >= RD && (k - RD) % RP == 0));
                if (t - DEB + 1 > last_flip[c] && t - DEB + 1 >= 0) begin
                    all = 1'b1;
                    for (int j = 0; j < DEB; j++)
                        if (s2_at(c, t - j) == lvl[c]) all = 1'b0;
                    if (all) begin
                        lvl[c] = ~lvl[c];
                        last_flip[c] = t;
                        rise[c] = lvl[c] ? t : -1;
                    end
                end
                exp_lv[c] = lvl[c];
            end
            t++;
        end
    end

    always @(negedge clk) begin
        if (valid) begin
            vectors++;
            if (bus.osign !== exp_os) begin
                miscompares++;
                $display("FAIL model_osign t=%0d: got %b expected %b", t, bus.osign, exp_os);
            end
            vectors++;
            if (bus.olevel !== exp_lv) begin
                miscompares++;
                $display("FAIL model_olevel t=%0d: got %b expected %b", t, bus.olevel, exp_lv);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    initial begin
        int pulses [$];
        int left [CH];
        int n;
        bus.isign = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_osign", 32'(bus.osign), 0);
        chk("reset_olevel", 32'(bus.olevel), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // single press held 6 cycles: level after E0+5, pulse after E0+6 only
        bus.isign[0] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk($sformatf("press_olevel0_n%0d", i), 32'(bus.olevel[0]), (i >= 6) ? 1 : 0);
            chk($sformatf("press_osign0_n%0d", i), 32'(bus.osign[0]), (i == 7) ? 1 : 0);
            chk($sformatf("press_osign1_n%0d", i), 32'(bus.osign[1]), 0);
            if (i == 6) bus.isign[0] = 1'b0;
        end
        repeat (10) @(negedge clk);

        // 3-cycle glitch is rejected
        bus.isign[0] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 3) bus.isign[0] = 1'b0;
            chk($sformatf("glitch_n%0d", i), 32'({bus.olevel[0], bus.osign[0]}), 0);
        end

        // 30-cycle hold: pulse at n=7, repeats at +8 then every +3 while held
        bus.isign[0] = 1'b1;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            if (bus.osign[0]) pulses.push_back(i);
            if (i == 30) bus.isign[0] = 1'b0;
        end
        chk("hold_count", 32'(pulses.size()), AUTO ? 9 : 1);
        if (pulses.size() >= 1) chk("hold_first", 32'(pulses[0]), 7);
        if (AUTO && pulses.size() >= 4) begin
            chk("hold_gap1", 32'(pulses[1] - pulses[0]), RD);
            chk("hold_gap2", 32'(pulses[2] - pulses[1]), RP);
            chk("hold_gap3", 32'(pulses[3] - pulses[2]), RP);
            chk("hold_last", 32'(pulses[pulses.size()-1]), 36);
        end
        repeat (10) @(negedge clk);

        // simultaneous press, reset mid-hold, re-press after release
        bus.isign = 2'b11;
        n = 0;
        while (bus.osign == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("dual_latency", 32'(n), 7);
        chk("dual_osign", 32'(bus.osign), 3);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_osign", 32'(bus.osign), 0);
        chk("rst_mid_olevel", 32'(bus.olevel), 0);
        reset = 1'b0;
        for (int i = 1; i <= DEB + 3; i++) begin
            @(negedge clk);
            chk($sformatf("repress_n%0d", i), 32'(bus.osign), (i == DEB + 3) ? 3 : 0);
        end
        bus.isign = '0;
        repeat (12) @(negedge clk);

        // random phase
        for (int c = 0; c < CH; c++) left[c] = 1;
        for (int cyc = 0; cyc < 2500; cyc++) begin
            for (int c = 0; c < CH; c++) begin
                left[c]--;
                if (left[c] <= 0) begin
                    bus.isign[c] = 1'($urandom_range(0, 1));
                    left[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40))
                                                          : int'($urandom_range(1, 7));
                end
            end
            reset = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        bus.isign = '0;
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
